mem_line_responder: RTL and testbench

- Memory-side responder that completes the I$/D$ line-fill protocol.
- Pops request packets delivered by a bus deserializer (DES-style full/read handshake) and services them against an internal line store of 16-byte lines.
- Reads return a 128-bit line packet to a bus serializer (SER-style valid/full handshake), addressed back to the requester's return ID.
- Writes update the store and produce no response.

---
 rtl/mem_line_responder_if.sv | 40 ++++
 rtl/mem_line_responder.sv | 214 +++++++++++++++++++++
 tb/tb_mem_line_responder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_responder_if.sv
// Purpose: groups the request (DES) and response (SER) packet buses of the
//          memory line responder into one bundle.
// Ports:   slave modport = responder side, master modport = DES/SER environment.
//          req_*    : request packet from the deserializer, req_read pops it.
//          rsp_*    : line response packet to the serializer, ser_full stalls it.
interface mem_line_responder_if;
    // request side (deserializer -> responder)
    logic         req_full;
    logic [14:0]  req_pAdr;
    logic [127:0] req_data;
    logic [3:0]   req_return;
    logic [3:0]   req_dest;
    logic         req_rw;
    logic [15:0]  req_size;
    logic         req_read;

    // response side (responder -> serializer)
    logic         rsp_valid;
    logic [14:0]  rsp_pAdr;
    logic [127:0] rsp_data;
    logic [3:0]   rsp_dest;
    logic [3:0]   rsp_return;
    logic         rsp_rw;
    logic [15:0]  rsp_size;
    logic         ser_full;

    modport slave (
        input  req_full, req_pAdr, req_data, req_return, req_dest, req_rw, req_size,
        output req_read,
        output rsp_valid, rsp_pAdr, rsp_data, rsp_dest, rsp_return, rsp_rw, rsp_size,
        input  ser_full
    );

    modport master (
        output req_full, req_pAdr, req_data, req_return, req_dest, req_rw, req_size,
        input  req_read,
        input  rsp_valid, rsp_pAdr, rsp_data, rsp_dest, rsp_return, rsp_rw, rsp_size,
        output ser_full
    );
endinterface

// File: rtl/mem_line_responder.sv
// Purpose: memory-side line-fill responder; queues DES request packets, writes
//          16-byte lines into a local store and answers reads with a 128-bit line packet.
// Latency: push at edge 0, pop at edge 1, rsp_valid after edge 1+LATENCY (read, idle, empty queue).
// Backpressure: req_read drops while the request queue is full; a response holds every
//          rsp_* field stable while ser_full is high and retires on the first edge without it.
// Ports:   clk, reset (async, active-low), bus (slave modport: req_* in / req_read out,
//          rsp_* out / ser_full in), busy (queue non-empty or FSM active), err (sticky bad size).
module mem_line_responder #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned LINES   = 2048,
    parameter logic [3:0]  MY_ID   = 4'b1111
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_line_responder_if.slave  bus,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam int unsigned IDX_W = $clog2(LINES);

    localparam logic [PTR_W:0]   FIFO_CAP = DEPTH[PTR_W:0];
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = LATENCY[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LAT_ONE  = 1;
    localparam logic [15:0]      LINE_BYTES = 16'd16;

    // Only the line index travels through the queue; pAdr[3:0] and the
    // destination field carry no meaning for the responder.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [127:0]     data;
        logic [3:0]       ret;
        logic             rw;
        logic [15:0]      size;
    } req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    req_t             fifo_mem [DEPTH];
    req_t             push_pkt;
    req_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    // ------------------------------------------------------------------
    // Service FSM and response registers
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] line_idx;
    logic [3:0]       dest_q;
    logic [127:0]     data_q;
    logic             head_legal;
    logic             do_write;
    logic             do_read;
    logic             err_q;

    // Line store: deliberately not reset, contents are undefined until written.
    logic [127:0]     line_store [LINES];

    logic             unused_bits;
    assign unused_bits = ^{bus.req_pAdr[3:0], bus.req_dest};

    assign push_pkt = '{
        idx:  bus.req_pAdr[4 +: IDX_W],
        data: bus.req_data,
        ret:  bus.req_return,
        rw:   bus.req_rw,
        size: bus.req_size
    };

    assign fifo_full  = (count == FIFO_CAP);
    assign fifo_empty = (count == '0);

    // Full is judged on the registered count, so a pop in the same cycle
    // does not open the slot until the next cycle (no bypass).
    assign bus.req_read = bus.req_full & ~fifo_full;
    assign push         = bus.req_read;
    assign pop          = (state == IDLE) & ~fifo_empty;

    assign head       = fifo_mem[rd_ptr];
    assign head_legal = (head.size == LINE_BYTES);
    assign do_write   = pop & head_legal &  head.rw;
    assign do_read    = pop & head_legal & ~head.rw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_pkt;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // Writes and illegal packets retire in IDLE, only reads leave it.
                if (do_read) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == LAT_ONE) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (!bus.ser_full) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            line_idx <= '0;
            dest_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (pop && !head_legal) begin
                err_q <= 1'b1;
            end
            if (do_read) begin
                line_idx <= head.idx;
                dest_q   <= head.ret;
                cnt      <= LAT_LOAD;
            end
            if (state == WAIT) begin
                cnt <= cnt - LAT_ONE;
                // Store read happens on the last access cycle so a write popped
                // earlier is always visible.
                if (cnt == LAT_ONE) begin
                    data_q <= line_store[line_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            line_store[head.idx] <= head.data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_pAdr   = {line_idx, 4'b0000};
    assign bus.rsp_data   = data_q;
    assign bus.rsp_dest   = dest_q;
    assign bus.rsp_return = MY_ID;
    assign bus.rsp_rw     = 1'b1;
    assign bus.rsp_size   = LINE_BYTES;

    assign busy = ~fifo_empty | (state != IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_mem_line_responder.sv
module tb_mem_line_responder;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic err;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] D1 = 128'hDEADBEEF_00112233_44556677_8899AABB;
    localparam logic [127:0] D2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    mem_line_responder_if bus();

    mem_line_responder #(
        .DEPTH(4),
        .LATENCY(2),
        .LINES(2048),
        .MY_ID(4'b1111)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [14:0] adr, input logic [127:0] d, input logic [3:0] ret,
                         input logic rw, input logic [15:0] sz);
        bus.req_pAdr   = adr;
        bus.req_data   = d;
        bus.req_return = ret;
        bus.req_dest   = 4'h0;
        bus.req_rw     = rw;
        bus.req_size   = sz;
    endtask

    // Present one packet and hold it until the edge that accepts it.
    task automatic send(input logic [14:0] adr, input logic [127:0] d, input logic [3:0] ret,
                        input logic rw, input logic [15:0] sz);
        int n;
        drive(adr, d, ret, rw, sz);
        bus.req_full = 1'b1;
        #1;
        n = 0;
        while (bus.req_read !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("send_accept", 128'(bus.req_read), 128'd1);
        tick();
        bus.req_full = 1'b0;
    endtask

    // Wait for a response (bounded), check it, then let it retire (ser_full low).
    task automatic wait_rsp(input string tag, input logic [14:0] adr, input logic [127:0] d,
                            input logic [3:0] dst);
        int n;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 128'(bus.rsp_valid), 128'd1);
        chk({tag, "_data"},  bus.rsp_data, d);
        chk({tag, "_pAdr"},  128'(bus.rsp_pAdr), 128'(adr));
        chk({tag, "_dest"},  128'(bus.rsp_dest), 128'(dst));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, m;
        logic r, v, seen;
        logic [127:0] d_s;
        logic [14:0]  a_s;
        logic [3:0]   dst_s;

        reset = 1'b0;
        bus.req_full = 1'b0;
        bus.ser_full = 1'b0;
        drive(15'h0, 128'h0, 4'h0, 1'b0, 16'h0);

        // ---------------- reset state ----------------
        #12;
        chk("rst_valid",  128'(bus.rsp_valid),  128'd0);
        chk("rst_read",   128'(bus.req_read),   128'd0);
        chk("rst_busy",   128'(busy),           128'd0);
        chk("rst_err",    128'(err),            128'd0);
        chk("rst_return", 128'(bus.rsp_return), 128'hF);
        chk("rst_rw",     128'(bus.rsp_rw),     128'd1);
        chk("rst_size",   128'(bus.rsp_size),   128'd16);
        chk("rst_data",   bus.rsp_data,         128'd0);
        chk("rst_pAdr",   128'(bus.rsp_pAdr),   128'd0);
        chk("rst_dest",   128'(bus.rsp_dest),   128'd0);
        #1;
        reset = 1'b1;
        tick();

        // ---------------- write then read, latency ----------------
        send(15'h0120, D1, 4'h2, 1'b1, 16'd16);
        tick();
        tick();
        chk("wr_idle_busy", 128'(busy), 128'd0);
        send(15'h0125, 128'h0, 4'h2, 1'b0, 16'd16);   // now just after edge 0
        chk("lat_e0_valid", 128'(bus.rsp_valid), 128'd0);
        chk("lat_e0_busy",  128'(busy), 128'd1);
        tick();
        chk("lat_e1_valid", 128'(bus.rsp_valid), 128'd0);
        tick();
        chk("lat_e2_valid", 128'(bus.rsp_valid), 128'd0);
        tick();
        chk("lat_e3_valid",  128'(bus.rsp_valid),  128'd1);
        chk("lat_e3_data",   bus.rsp_data,         D1);
        chk("lat_e3_pAdr",   128'(bus.rsp_pAdr),   128'h0120);
        chk("lat_e3_dest",   128'(bus.rsp_dest),   128'h2);
        chk("lat_e3_size",   128'(bus.rsp_size),   128'd16);
        chk("lat_e3_rw",     128'(bus.rsp_rw),     128'd1);
        chk("lat_e3_return", 128'(bus.rsp_return), 128'hF);
        tick();
        chk("lat_e4_valid", 128'(bus.rsp_valid), 128'd0);
        tick();
        chk("lat_done_busy", 128'(busy), 128'd0);

        // ---------------- backpressure ----------------
        send(15'h0340, D2, 4'h5, 1'b1, 16'd16);
        tick();
        tick();
        bus.ser_full = 1'b1;
        send(15'h034C, 128'h0, 4'h5, 1'b0, 16'd16);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 128'(bus.rsp_valid), 128'd1);
            chk("bp_data",  bus.rsp_data,        D2);
            chk("bp_pAdr",  128'(bus.rsp_pAdr),  128'h0340);
            chk("bp_dest",  128'(bus.rsp_dest),  128'h5);
            tick();
        end
        bus.ser_full = 1'b0;
        tick();
        chk("bp_retired_valid", 128'(bus.rsp_valid), 128'd0);
        chk("bp_retired_busy",  128'(busy), 128'd0);

        // ---------------- queue full ----------------
        for (int i = 0; i < 5; i++) begin
            send({11'(10 + i), 4'h0}, {4{32'hA000_0000 + 32'(i)}}, 4'h0, 1'b1, 16'd16);
        end
        tick();
        tick();
        bus.ser_full = 1'b1;
        k = 0;
        for (int c = 0; c < 15; c++) begin
            drive({11'(10 + (k % 5)), 4'h0}, 128'h0, 4'(k), 1'b0, 16'd16);
            bus.req_full = 1'b1;
            #1;
            r = bus.req_read;
            tick();
            if (r) k++;
        end
        chk("full_pops",  128'(k), 128'd5);
        chk("full_read",  128'(bus.req_read), 128'd0);
        chk("full_busy",  128'(busy), 128'd1);
        bus.ser_full = 1'b0;
        m = 0;
        for (int c = 0; c < 80 && m < 6; c++) begin
            if (k < 6) begin
                drive({11'(10 + (k % 5)), 4'h0}, 128'h0, 4'(k), 1'b0, 16'd16);
                bus.req_full = 1'b1;
            end else begin
                bus.req_full = 1'b0;
            end
            #1;
            r     = bus.req_read;
            v     = bus.rsp_valid;
            d_s   = bus.rsp_data;
            a_s   = bus.rsp_pAdr;
            dst_s = bus.rsp_dest;
            tick();
            if (r) k++;
            if (v) begin
                chk("full_rsp_data", d_s, {4{32'hA000_0000 + 32'(m % 5)}});
                chk("full_rsp_pAdr", 128'(a_s), 128'({11'(10 + (m % 5)), 4'h0}));
                chk("full_rsp_dest", 128'(dst_s), 128'(m));
                m++;
            end
        end
        bus.req_full = 1'b0;
        chk("full_rsp_count", 128'(m), 128'd6);
        chk("full_push_count", 128'(k), 128'd6);
        tick();
        tick();
        chk("full_done_busy", 128'(busy), 128'd0);

        // ---------------- illegal size ----------------
        send(15'h0120, 128'h0, 4'h3, 1'b0, 16'd8);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
            tick();
        end
        chk("bad_no_rsp", 128'(seen), 128'd0);
        chk("bad_err",    128'(err),  128'd1);
        chk("bad_busy",   128'(busy), 128'd0);
        send(15'h0128, 128'h0, 4'h3, 1'b0, 16'd16);
        wait_rsp("bad_next", 15'h0120, D1, 4'h3);
        chk("bad_err_sticky", 128'(err), 128'd1);

        // ---------------- async reset mid-WAIT ----------------
        send(15'h0340, 128'h0, 4'h6, 1'b0, 16'd16);
        send(15'h0120, 128'h0, 4'h7, 1'b0, 16'd16);
        send(15'h0120, 128'h0, 4'h8, 1'b0, 16'd16);
        chk("ar_pre_busy",  128'(busy), 128'd1);
        chk("ar_pre_valid", 128'(bus.rsp_valid), 128'd0);
        #3;
        reset = 1'b0;
        #1;
        chk("ar_valid", 128'(bus.rsp_valid), 128'd0);
        chk("ar_busy",  128'(busy), 128'd0);
        chk("ar_err",   128'(err),  128'd0);
        #2;
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        chk("ar_no_rsp",    128'(seen), 128'd0);
        chk("ar_post_busy", 128'(busy), 128'd0);

        // ---------------- wrap: alternating write/read, lines 0..5 ----------------
        for (int j = 0; j < 6; j++) begin
            send({11'(j), 4'h0}, {4{32'h5A5A_0000 + 32'(j * 17)}}, 4'h0, 1'b1, 16'd16);
            send({11'(j), 4'(j)}, 128'h0, 4'(j + 1), 1'b0, 16'd16);
            wait_rsp("wrap", {11'(j), 4'h0}, {4{32'h5A5A_0000 + 32'(j * 17)}}, 4'(j + 1));
        end
        tick();
        chk("wrap_busy", 128'(busy), 128'd0);
        chk("wrap_err",  128'(err),  128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
